// File: rtl/step_profiler_pkg.sv
// Shared types and constants for the stepper motion profiler.
// Holds the FSM state encoding, the half-step coil table and default ramp timing.
package step_profiler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCEL  = 2'd1,
    ST_CRUISE = 2'd2,
    ST_DECEL  = 2'd3
  } state_t;

  // Index 0 sits in the least significant nibble.
  localparam logic [7:0][3:0] PHASE_TABLE = {
    4'b0110, 4'b1110, 4'b1100, 4'b1101,
    4'b1001, 4'b1011, 4'b0011, 4'b0111
  };

  localparam int DEF_START_PERIOD = 131072;
  localparam int DEF_MIN_PERIOD   = 32768;
  localparam int DEF_RAMP_DEC     = 8192;

endpackage

// File: rtl/phase_seq.sv
// Half-step phase sequencer: 3-bit table index advanced by step/dir,
// with the coil pattern registered alongside the index.
module phase_seq
  import step_profiler_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       step,
  input  logic       dir,
  output logic [3:0] phaseout
);

  logic [2:0] idx_r;
  logic [2:0] idx_n_s;

  // Next table index, wrapping modulo 8 in either direction.
  always_comb begin
    idx_n_s = idx_r;
    if (step) begin
      if (dir) begin
        idx_n_s = idx_r + 3'd1;
      end else begin
        idx_n_s = idx_r - 3'd1;
      end
    end else begin
      idx_n_s = idx_r;
    end
  end

  // Index and coil pattern registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx_r    <= 3'd0;
      phaseout <= PHASE_TABLE[3'd0];
    end else begin
      idx_r    <= idx_n_s;
      phaseout <= PHASE_TABLE[idx_n_s];
    end
  end

endmodule

// File: rtl/step_profiler.sv
// Trapezoidal stepper move profiler: accepts a move, ramps the step period
// down to cruise and back up, supports ramped abort and tracks position.
module step_profiler
  import step_profiler_pkg::*;
#(
  parameter int STEP_W       = 16,
  parameter int POS_W        = 24,
  parameter int PER_W        = 20,
  parameter int START_PERIOD = DEF_START_PERIOD,
  parameter int MIN_PERIOD   = DEF_MIN_PERIOD,
  parameter int RAMP_DEC     = DEF_RAMP_DEC
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_dir,
  input  logic [STEP_W-1:0]       cmd_steps,
  input  logic                    abort,
  output logic                    busy,
  output logic                    done,
  output logic [3:0]              phaseout,
  output logic signed [POS_W-1:0] position
);

  localparam logic [PER_W-1:0] START_P       = PER_W'(START_PERIOD);
  localparam logic [PER_W-1:0] RAMP_P        = PER_W'(RAMP_DEC);
  localparam logic [PER_W:0]   START_X       = (PER_W+1)'(START_PERIOD);
  localparam logic [PER_W:0]   RAMP_X        = (PER_W+1)'(RAMP_DEC);
  localparam logic [PER_W:0]   ACCEL_FLOOR_X = (PER_W+1)'(MIN_PERIOD + RAMP_DEC);

  state_t            state_r, state_n_s;
  logic              dir_r, dir_n_s;
  logic [STEP_W-1:0] rem_r, rem_n_s, rem_dec_s;
  logic [STEP_W-1:0] acc_r, acc_n_s;
  logic [STEP_W:0]   abort_cap_s;
  logic [PER_W-1:0]  per_r, per_n_s, per_up_s;
  logic [PER_W:0]    per_sum_s;
  logic [PER_W-1:0]  timer_r, timer_n_s;
  logic              step_s;
  logic              done_n_s;
  logic [POS_W-1:0]  position_r;
  logic              done_r;
  logic              cmd_ready_r;
  logic              busy_r;

  // Next-state, ramp and step-timing decisions.
  always_comb begin
    state_n_s   = state_r;
    dir_n_s     = dir_r;
    rem_n_s     = rem_r;
    acc_n_s     = acc_r;
    per_n_s     = per_r;
    timer_n_s   = timer_r;
    step_s      = 1'b0;
    done_n_s    = 1'b0;
    abort_cap_s = '0;
    rem_dec_s   = rem_r - STEP_W'(1);
    per_sum_s   = {1'b0, per_r} + RAMP_X;
    per_up_s    = (per_sum_s > START_X) ? START_P : per_sum_s[PER_W-1:0];

    case (state_r)
      ST_IDLE: begin
        if (cmd_valid) begin
          dir_n_s   = cmd_dir;
          rem_n_s   = cmd_steps;
          per_n_s   = START_P;
          acc_n_s   = '0;
          timer_n_s = START_P - PER_W'(1);
          if (cmd_steps == '0) begin
            done_n_s = 1'b1;
          end else begin
            state_n_s = ST_ACCEL;
          end
        end else begin
          state_n_s = ST_IDLE;
        end
      end
      ST_ACCEL, ST_CRUISE, ST_DECEL: begin
        if (timer_r == '0) begin
          step_s  = 1'b1;
          rem_n_s = rem_dec_s;
          if (rem_dec_s == '0) begin
            state_n_s = ST_IDLE;
            done_n_s  = 1'b1;
          end else if (rem_dec_s <= acc_r) begin
            state_n_s = ST_DECEL;
            per_n_s   = per_up_s;
          end else if ((state_r == ST_ACCEL) && ({1'b0, per_r} >= ACCEL_FLOOR_X)) begin
            per_n_s = per_r - RAMP_P;
            acc_n_s = acc_r + STEP_W'(1);
          end else if (state_r == ST_ACCEL) begin
            state_n_s = ST_CRUISE;
          end else begin
            state_n_s = state_r;
          end
          timer_n_s = per_n_s - PER_W'(1);
        end else begin
          timer_n_s = timer_r - PER_W'(1);
        end
        // Abort trims the remaining steps to what the ramp-down needs.
        abort_cap_s = {1'b0, acc_n_s} + (STEP_W+1)'(1);
        if (abort && (state_r != ST_DECEL) && (state_n_s != ST_IDLE)) begin
          state_n_s = ST_DECEL;
          if ({1'b0, rem_n_s} > abort_cap_s) begin
            rem_n_s = abort_cap_s[STEP_W-1:0];
          end else begin
            rem_n_s = rem_n_s;
          end
        end else begin
          state_n_s = state_n_s;
        end
      end
      default: begin
        state_n_s = ST_IDLE;
      end
    endcase
  end

  // Profile state, position and registered status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      dir_r       <= 1'b0;
      rem_r       <= '0;
      acc_r       <= '0;
      per_r       <= START_P;
      timer_r     <= '0;
      position_r  <= '0;
      done_r      <= 1'b0;
      cmd_ready_r <= 1'b1;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_n_s;
      dir_r       <= dir_n_s;
      rem_r       <= rem_n_s;
      acc_r       <= acc_n_s;
      per_r       <= per_n_s;
      timer_r     <= timer_n_s;
      done_r      <= done_n_s;
      cmd_ready_r <= (state_n_s == ST_IDLE);
      busy_r      <= (state_n_s != ST_IDLE);
      if (step_s) begin
        position_r <= dir_r ? (position_r + POS_W'(1)) : (position_r - POS_W'(1));
      end else begin
        position_r <= position_r;
      end
    end
  end

  phase_seq u_phase_seq (
    .clk      (clk),
    .reset    (reset),
    .step     (step_s),
    .dir      (dir_r),
    .phaseout (phaseout)
  );

  assign cmd_ready = cmd_ready_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign position  = position_r;

endmodule

// File: tb/tb_step_profiler.sv
// Self-checking bench for step_profiler: a step-level move planner predicts
// step times, coil pattern and position; directed scenarios pin literal values.
module tb_step_profiler;

  localparam int S  = 8;
  localparam int MN = 4;
  localparam int D  = 2;
  localparam int PH_ACC = 0;
  localparam int PH_CRU = 1;
  localparam int PH_DEC = 2;

  logic               clk = 1'b0;
  logic               reset;
  logic               cmd_valid;
  logic               cmd_ready;
  logic               cmd_dir;
  logic [15:0]        cmd_steps;
  logic               abort;
  logic               busy;
  logic               done;
  logic [3:0]         phaseout;
  logic signed [23:0] position;

  step_profiler #(
    .STEP_W(16), .POS_W(24), .PER_W(20),
    .START_PERIOD(S), .MIN_PERIOD(MN), .RAMP_DEC(D)
  ) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_dir(cmd_dir), .cmd_steps(cmd_steps), .abort(abort), .busy(busy),
    .done(done), .phaseout(phaseout), .position(position)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [3:0] tb_tab [8] = '{4'b0111, 4'b0011, 4'b1011, 4'b1001,
                             4'b1101, 4'b1100, 4'b1110, 4'b0110};

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit m_busy = 1'b0;
  bit m_done = 1'b0;
  bit m_dir  = 1'b0;
  int m_pos  = 0;
  int m_idx  = 0;
  int m_n    = 0;
  int m_cnt  = 0;
  int m_next = 0;
  int iv[$];
  int phq[$];
  int acq[$];

  // Step-by-step plan of intervals, ramp phase and accel count for an n-step move.
  function automatic void plan(input int n);
    int per, acc, p;
    iv.delete(); phq.delete(); acq.delete();
    per = S; acc = 0; p = PH_ACC;
    for (int k = 1; k <= n; k++) begin
      iv.push_back(per); phq.push_back(p); acq.push_back(acc);
      if (k < n) begin
        if (n - k <= acc) begin
          p = PH_DEC;
          per = (per + D > S) ? S : per + D;
        end else if (p == PH_ACC) begin
          if (per - D >= MN) begin per -= D; acc++; end
          else p = PH_CRU;
        end
      end
    end
  endfunction

  always @(posedge clk) begin
    int rem, r;
    cyc++;
    if (reset) begin
      m_busy = 1'b0; m_done = 1'b0; m_pos = 0; m_idx = 0;
    end else begin
      m_done = 1'b0;
      if (!m_busy) begin
        if (cmd_valid) begin
          if (cmd_steps == 16'd0) m_done = 1'b1;
          else begin
            plan(int'(cmd_steps));
            m_dir = cmd_dir; m_n = int'(cmd_steps); m_cnt = 0;
            m_next = cyc + iv[0]; m_busy = 1'b1;
          end
        end
      end else if (cyc == m_next) begin
        m_cnt++;
        m_pos += m_dir ? 1 : -1;
        m_idx = (m_idx + (m_dir ? 1 : 7)) % 8;
        if (m_cnt == m_n) begin m_busy = 1'b0; m_done = 1'b1; end
        else m_next = cyc + iv[m_cnt];
      end else if (abort && phq[m_cnt] != PH_DEC) begin
        rem = m_n - m_cnt;
        r = (rem < acq[m_cnt] + 1) ? rem : acq[m_cnt] + 1;
        m_n = m_cnt + r;
        for (int i = 1; i < r; i++) begin
          iv[m_cnt + i]  = (iv[m_cnt] + i * D > S) ? S : iv[m_cnt] + i * D;
          phq[m_cnt + i] = PH_DEC;
        end
      end
    end
  end

  // Every-cycle comparison of DUT outputs against the model.
  always @(negedge clk) begin
    if (cyc > 0) begin
      chk("cmp_ready", int'(cmd_ready), int'(!m_busy));
      chk("cmp_busy", int'(busy), int'(m_busy));
      chk("cmp_done", int'(done), int'(m_done));
      chk("cmp_phase", int'(phaseout), int'(tb_tab[m_idx]));
      chk("cmp_pos", int'(position), m_pos);
    end
  end

  // ---------------- step monitor ----------------
  logic [3:0] prev_ph;
  int step_cyc[$];
  int step_ph[$];

  always @(posedge clk) begin
    #1;
    if (!reset && phaseout !== prev_ph) begin
      step_cyc.push_back(cyc);
      step_ph.push_back(int'(phaseout));
    end
    prev_ph = phaseout;
  end

  function automatic int get_cyc(input int i);
    return (i < step_cyc.size()) ? step_cyc[i] : -1;
  endfunction

  function automatic int get_ph(input int i);
    return (i < step_ph.size()) ? step_ph[i] : -1;
  endfunction

  // ---------------- directed stimulus ----------------
  int acc_cyc;
  int dc;

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic send(input logic dir, input int steps);
    step_cyc.delete(); step_ph.delete();
    cmd_valid = 1'b1; cmd_dir = dir; cmd_steps = 16'(steps);
    @(negedge clk);
    acc_cyc = cyc;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int done_cyc);
    done_cyc = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin done_cyc = cyc; break; end
    end
    chk("done_seen", int'(done_cyc >= 0), 1);
  endtask

  task automatic wait_steps(input int n, input int budget);
    int i;
    i = 0;
    while (step_cyc.size() < n && i < budget) begin
      @(negedge clk);
      i++;
    end
    chk("steps_seen", int'(step_cyc.size() >= n), 1);
  endtask

  int exp32 [10] = '{8, 6, 4, 4, 4, 4, 4, 4, 6, 8};

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_dir = 1'b0; cmd_steps = 16'd0; abort = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_ready", int'(cmd_ready), 1);
    chk("rst_phase", int'(phaseout), 7);

    // Reset in the middle of a move.
    send(1'b1, 20);
    repeat (18) @(negedge clk);
    chk("mid_busy", int'(busy), 1);
    do_reset();
    chk("r30_phase", int'(phaseout), 4'b0111);
    chk("r30_pos", int'(position), 0);
    chk("r30_ready", int'(cmd_ready), 1);
    chk("r30_busy", int'(busy), 0);
    chk("r30_done", int'(done), 0);

    // Short forward move: 8,6,8.
    send(1'b1, 3);
    wait_done(200, dc);
    chk("r31_count", step_cyc.size(), 3);
    chk("r31_iv0", get_cyc(0) - acc_cyc, 8);
    chk("r31_iv1", get_cyc(1) - get_cyc(0), 6);
    chk("r31_iv2", get_cyc(2) - get_cyc(1), 8);
    chk("r31_ph0", get_ph(0), 4'b0011);
    chk("r31_ph1", get_ph(1), 4'b1011);
    chk("r31_ph2", get_ph(2), 4'b1001);
    chk("r31_done_at", dc - get_cyc(2), 0);
    chk("r31_pos", int'(position), 3);
    @(negedge clk);
    chk("r31_done_low", int'(done), 0);

    // Full trapezoid in reverse.
    do_reset();
    send(1'b0, 10);
    wait_done(300, dc);
    chk("r32_count", step_cyc.size(), 10);
    for (int k = 0; k < 10; k++)
      chk($sformatf("r32_iv%0d", k), get_cyc(k) - ((k == 0) ? acc_cyc : get_cyc(k - 1)), exp32[k]);
    chk("r32_total", get_cyc(9) - acc_cyc, 52);
    chk("r32_phase", int'(phaseout), 4'b1110);
    chk("r32_pos", int'(position), -10);

    // Abort during cruise.
    do_reset();
    send(1'b1, 100);
    wait_steps(5, 200);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    wait_done(500, dc);
    chk("r33_count", step_cyc.size(), 8);
    chk("r33_iv6", get_cyc(5) - get_cyc(4), 4);
    chk("r33_iv7", get_cyc(6) - get_cyc(5), 6);
    chk("r33_iv8", get_cyc(7) - get_cyc(6), 8);
    chk("r33_pos", int'(position), 8);
    chk("r33_phase", int'(phaseout), 4'b0111);

    // Zero-step command, then a command held while busy.
    do_reset();
    send(1'b1, 0);
    chk("r34_zero_done", int'(done), 1);
    chk("r34_zero_busy", int'(busy), 0);
    chk("r34_zero_phase", int'(phaseout), 4'b0111);
    @(negedge clk);
    chk("r34_zero_done_low", int'(done), 0);
    step_cyc.delete(); step_ph.delete();
    cmd_valid = 1'b1; cmd_dir = 1'b1; cmd_steps = 16'd3;
    @(negedge clk);
    acc_cyc = cyc;
    cmd_dir = 1'b0; cmd_steps = 16'd50;
    chk("r34_ready_busy", int'(cmd_ready), 0);
    wait_steps(2, 100);
    cmd_valid = 1'b0;
    wait_done(200, dc);
    chk("r34_iv0", get_cyc(0) - acc_cyc, 8);
    chk("r34_iv1", get_cyc(1) - get_cyc(0), 6);
    chk("r34_iv2", get_cyc(2) - get_cyc(1), 8);
    chk("r34_pos", int'(position), 3);
    chk("r34_phase", int'(phaseout), 4'b1001);

    // Forward 8 (abort with the handshake is ignored), then reverse 8.
    do_reset();
    step_cyc.delete(); step_ph.delete();
    cmd_valid = 1'b1; cmd_dir = 1'b1; cmd_steps = 16'd8; abort = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0; abort = 1'b0;
    wait_done(300, dc);
    chk("r35_fwd_count", step_cyc.size(), 8);
    chk("r35_fwd_pos", int'(position), 8);
    chk("r35_fwd_phase", int'(phaseout), 4'b0111);
    send(1'b0, 8);
    wait_done(300, dc);
    chk("r35_rev_pos", int'(position), 0);
    chk("r35_rev_phase", int'(phaseout), 4'b0111);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
